// File: rtl/page_access_arbiter_pkg.sv
// Shared definitions for the page access arbiter: selector register map,
// arbiter state encoding and small arithmetic helpers.
package page_pkg;

    // Register map decoded by the page selector slave
    localparam logic [7:0] SR       = 8'h00;
    localparam logic [7:0] CR       = 8'h04;
    localparam logic [7:0] CR_S     = 8'h08;
    localparam logic [7:0] CR_C     = 8'h0C;
    localparam logic [7:0] PAGE_NUM = 8'h10;

    typedef enum logic [1:0] {
        IDLE,
        CFG_WR,
        GRANT
    } arb_state_t;

    // Increment with wrap-around at n (n need not be a power of two)
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

    // Burstcount width: max(1, clog2(max_burst + 1))
    function automatic int unsigned bcw_of(input int unsigned max_burst);
        int unsigned w;
        w = $clog2(max_burst + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Index width for n requesters, never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/page_access_arbiter_if.sv
// Avalon-MM configuration bus carrying the page selector register writes.
interface avmm_if #(
    parameter int unsigned AW  = 16,
    parameter int unsigned DW  = 64,
    parameter int unsigned BCW = 1
);
    logic [AW-1:0]  address;
    logic           read;
    logic           write;
    logic [DW-1:0]  writedata;
    logic [BCW-1:0] burstcount;
    logic           waitrequest;
    logic           readdatavalid;
    logic [DW-1:0]  readdata;

    modport master (
        output address,
        output read,
        output write,
        output writedata,
        output burstcount,
        input  waitrequest,
        input  readdatavalid,
        input  readdata
    );

    modport slave (
        input  address,
        input  read,
        input  write,
        input  writedata,
        input  burstcount,
        output waitrequest,
        output readdatavalid,
        output readdata
    );

endinterface

// File: rtl/page_access_arbiter_rr.sv
// Combinational round-robin picker: lowest requesting index at or after
// rr_ptr (wrapping) wins.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    rr_ptr,
    output logic [N_REQ-1:0] win_onehot,
    output logic [IW-1:0]    win_idx,
    output logic             win_any
);

    int unsigned cand;

    always_comb begin
        win_any    = 1'b0;
        win_idx    = '0;
        win_onehot = '0;
        cand       = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = (32'(rr_ptr) + k) % N_REQ;
            if (!win_any && req[cand]) begin
                win_any = 1'b1;
                win_idx = IW'(cand);
            end
        end
        if (win_any) begin
            win_onehot[win_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/page_access_arbiter.sv
// Round-robin arbiter for the paged memory window; reprograms the selector's
// PAGE_NUM register over Avalon-MM before granting a different page.
module page_access_arbiter
    import page_pkg::*;
#(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned PAGE_COUNT = 4,
    parameter int unsigned AW         = 16,
    parameter int unsigned DW         = 64,
    parameter int unsigned MAX_BURST  = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [N_REQ-1:0]                     req,
    input  logic [N_REQ*$clog2(PAGE_COUNT)-1:0]  req_page,
    input  logic [N_REQ-1:0]                     release_pulse,
    output logic [N_REQ-1:0]                     gnt,
    avmm_if.master                               cfg,
    output logic [$clog2(PAGE_COUNT)-1:0]        cur_page,
    output logic                                 busy,
    output logic                                 err_oor
);

    localparam int unsigned PCW = $clog2(PAGE_COUNT);
    localparam int unsigned IW  = idx_width(N_REQ);
    localparam int unsigned BCW = bcw_of(MAX_BURST);

    arb_state_t     state, state_nxt;
    logic [IW-1:0]  sel_idx, sel_idx_nxt;
    logic [PCW-1:0] sel_page, sel_page_nxt;
    logic [PCW-1:0] cur_page_nxt;
    logic           cur_valid, cur_valid_nxt;
    logic [IW-1:0]  rr_ptr, rr_ptr_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic           err_oor_nxt;

    logic           write_q, write_nxt;
    logic [AW-1:0]  address_q, address_nxt;
    logic [DW-1:0]  writedata_q, writedata_nxt;

    logic [N_REQ-1:0] win_onehot;
    logic [IW-1:0]    win_idx;
    logic             win_any;
    logic [PCW-1:0]   cand_page;
    logic             unused_ok;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_rr (
        .req        (req),
        .rr_ptr     (rr_ptr),
        .win_onehot (win_onehot),
        .win_idx    (win_idx),
        .win_any    (win_any)
    );

    assign cand_page      = req_page[win_idx*PCW +: PCW];
    assign busy           = (state != IDLE);

    assign cfg.write      = write_q;
    assign cfg.address    = address_q;
    assign cfg.writedata  = writedata_q;
    assign cfg.read       = 1'b0;
    assign cfg.burstcount = BCW'(1);

    // Read path of the config bus is never used
    assign unused_ok = ^{cfg.readdatavalid, cfg.readdata};

    always_comb begin
        state_nxt     = state;
        sel_idx_nxt   = sel_idx;
        sel_page_nxt  = sel_page;
        cur_page_nxt  = cur_page;
        cur_valid_nxt = cur_valid;
        rr_ptr_nxt    = rr_ptr;
        gnt_nxt       = gnt;
        err_oor_nxt   = 1'b0;
        write_nxt     = write_q;
        address_nxt   = address_q;
        writedata_nxt = writedata_q;

        unique case (state)
            IDLE: begin
                if (win_any) begin
                    sel_idx_nxt  = win_idx;
                    sel_page_nxt = cand_page;
                    if (32'(cand_page) >= PAGE_COUNT) begin
                        // Skip past the offender so others are not starved
                        err_oor_nxt = 1'b1;
                        rr_ptr_nxt  = IW'(wrap_inc(32'(win_idx), N_REQ));
                    end else if (cur_valid && (cand_page == cur_page)) begin
                        state_nxt = GRANT;
                        gnt_nxt   = win_onehot;
                    end else begin
                        state_nxt     = CFG_WR;
                        write_nxt     = 1'b1;
                        address_nxt   = AW'(PAGE_NUM);
                        writedata_nxt = DW'(cand_page);
                    end
                end
            end

            CFG_WR: begin
                // An issued write always completes, even if the request drops
                if (!cfg.waitrequest) begin
                    write_nxt     = 1'b0;
                    cur_page_nxt  = sel_page;
                    cur_valid_nxt = 1'b1;
                    if (req[sel_idx]) begin
                        state_nxt = GRANT;
                        gnt_nxt   = N_REQ'(1) << sel_idx;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end

            GRANT: begin
                if (release_pulse[sel_idx] || !req[sel_idx]) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = '0;
                    rr_ptr_nxt = IW'(wrap_inc(32'(sel_idx), N_REQ));
                end
            end

            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sel_idx     <= '0;
            sel_page    <= '0;
            cur_page    <= '0;
            cur_valid   <= 1'b0;
            rr_ptr      <= '0;
            gnt         <= '0;
            err_oor     <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= '0;
            writedata_q <= '0;
        end else begin
            state       <= state_nxt;
            sel_idx     <= sel_idx_nxt;
            sel_page    <= sel_page_nxt;
            cur_page    <= cur_page_nxt;
            cur_valid   <= cur_valid_nxt;
            rr_ptr      <= rr_ptr_nxt;
            gnt         <= gnt_nxt;
            err_oor     <= err_oor_nxt;
            write_q     <= write_nxt;
            address_q   <= address_nxt;
            writedata_q <= writedata_nxt;
        end
    end

endmodule
